data_mem_responder: RTL and testbench

Responder end of the CPU data-memory interface. It accepts word read/write requests from the datapath and stores them in a word-addressed RAM. Each request is answered after a programmable wait-state count. A built-in write checker observes every completed store and raises sticky pass/fail flags, so program completion is decided in hardware rather than by a bench monitor. It sits between the DataPath data-memory port and the top level, and replaces the bare data memory.

---
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder.sv | 129 ++++++++++++
 tb/tb_data_mem_responder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Handshake bus between the datapath data-memory port (master) and the
// data-memory responder (slave).
interface data_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM answering datapath requests after WAIT_CYCLES wait
// states, with a store checker that raises sticky pass/fail verdicts.
module data_mem_responder #(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned WAIT_CYCLES  = 2,
    parameter logic [31:0] PASS_ADDR    = 32'd84,
    parameter logic [31:0] PASS_DATA    = 32'd7,
    parameter logic [31:0] SCRATCH_ADDR = 32'd80
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    output logic                 pass,
    output logic                 fail,
    output logic [15:0]          write_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        lat_we;
    logic        lat_err;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] mem [DEPTH];

    logic [AW-1:0] rd_idx;
    logic          rd_err;
    logic          rd_we;
    logic          go_resp;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
    endfunction

    // With no wait states RESP is entered straight from IDLE, so the response
    // must be built from the live request rather than the latched copy.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        rd_idx = lat_addr[AW+1:2];
        rd_err = lat_err;
        rd_we  = lat_we;
        if (state == IDLE) begin
            rd_idx = bus.addr[AW+1:2];
            rd_err = addr_bad(bus.addr);
            rd_we  = bus.we;
        end
        go_resp = ((state == IDLE) && bus.req && (WAIT_CYCLES == 0))
               || ((state == WAIT) && (wait_cnt == 4'd0));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            lat_we      <= 1'b0;
            lat_err     <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            bus.rdata   <= '0;
            bus.ready   <= 1'b0;
            bus.busy    <= 1'b0;
            bus.err     <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            write_count <= '0;
        end else begin
            bus.ready <= 1'b0;
            bus.err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.req) begin
                        lat_we    <= bus.we;
                        lat_addr  <= bus.addr;
                        lat_wdata <= bus.wdata;
                        lat_err   <= addr_bad(bus.addr);
                        bus.busy  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) state <= RESP;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                RESP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    // Only good stores reach the checker; the first verdict is terminal.
                    if (lat_we && !lat_err) begin
                        if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
                        if ((lat_addr == PASS_ADDR) && (lat_wdata == PASS_DATA)) begin
                            pass     <= 1'b1;
                            state    <= DONE;
                            bus.busy <= 1'b1;
                        end else if (lat_addr != SCRATCH_ADDR) begin
                            fail     <= 1'b1;
                            state    <= DONE;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase

            if (go_resp) begin
                bus.ready <= 1'b1;
                bus.err   <= rd_err;
                if (!rd_we) bus.rdata <= rd_err ? '0 : mem[rd_idx];
            end
        end
    end

    // NOTE: the RAM has no reset; a reset only discards the pending access, contents survive.
    always_ff @(posedge clk) begin
        if ((state == RESP) && lat_we && !lat_err) mem[lat_addr[AW+1:2]] <= lat_wdata;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a WAIT_CYCLES=2 instance for the
// main scenarios and a WAIT_CYCLES=0 instance for back-to-back request spacing.
module tb_data_mem_responder;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic        is_read;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pass, fail, pass0, fail0;
    logic [15:0] wc, wc0;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t sb0[$];

    always #5 clk = ~clk;

    data_mem_responder_if bus();
    data_mem_responder_if bus0();

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .pass(pass), .fail(fail), .write_count(wc)
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .pass(pass0), .fail(fail0), .write_count(wc0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitors: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'(bus.ready), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_err", 32'(bus.err), 32'(e.err));
                if (e.is_read) check("resp_rdata", bus.rdata, e.rdata);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && bus0.ready) begin
            if (sb0.size() == 0) begin
                check("unexpected_ready_w0", 32'(bus0.ready), 32'd0);
            end else begin
                exp_t e;
                e = sb0.pop_front();
                check("resp_err_w0", 32'(bus0.err), 32'(e.err));
                if (e.is_read) check("resp_rdata_w0", bus0.rdata, e.rdata);
            end
        end
    end

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic exp_err, input logic [31:0] exp_rd);
        int lat;
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        sb.push_back('{is_read: !w, err: exp_err, rdata: exp_rd});
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.req = 1'b0;
        end while (!bus.ready && lat < 20);
        check("latency", 32'(lat), 32'd3);
        check("busy_in_resp", 32'(bus.busy), 32'd1);
    endtask

    task automatic no_resp(input logic w, input logic [31:0] a, input logic [31:0] d);
        int seen;
        seen = 0;
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.ready) seen++;
        end
        bus.req = 1'b0;
        check("done_no_ready", 32'(seen), 32'd0);
    endtask

    task automatic check_flags(input string tag, input logic p, input logic f, input logic [15:0] n);
        check({tag, "_pass"}, 32'(pass), 32'(p));
        check({tag, "_fail"}, 32'(fail), 32'(f));
        check({tag, "_wcount"}, 32'(wc), 32'(n));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.req = 1'b0;  bus.we = 1'b0;  bus.addr = '0;  bus.wdata = '0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check_flags("rst", 1'b0, 1'b0, 16'd0);

        // Scratch store then read back.
        do_req(1'b1, 32'd80, 32'h0000_0005, 1'b0, 32'd0);
        @(negedge clk);
        check_flags("scratch", 1'b0, 1'b0, 16'd1);
        do_req(1'b0, 32'd80, 32'd0, 1'b0, 32'd5);

        // Misaligned and out-of-range accesses: err pulse, no RAM or count change.
        do_req(1'b1, 32'd82, 32'd99, 1'b1, 32'd0);
        do_req(1'b1, 32'(4 * DEPTH), 32'd99, 1'b1, 32'd0);
        do_req(1'b0, 32'd80, 32'd0, 1'b0, 32'd5);
        do_req(1'b0, 32'(4 * DEPTH), 32'd0, 1'b1, 32'd0);
        do_req(1'b0, 32'd81, 32'd0, 1'b1, 32'd0);
        @(negedge clk);
        check_flags("addr_err", 1'b0, 1'b0, 16'd1);

        // Reset in the middle of a write's wait states discards it.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'd80; bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.req = 1'b0;
        check("wait_busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_rdata", bus.rdata, 32'd0);
        check("async_rst_wcount", 32'(wc), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_flags("after_abort", 1'b0, 1'b0, 16'd0);
        do_req(1'b0, 32'd80, 32'd0, 1'b0, 32'd5);

        // Wrong data at the pass address: fail, then DONE ignores everything.
        do_req(1'b1, 32'd84, 32'd3, 1'b0, 32'd0);
        @(negedge clk);
        check_flags("wrong_data", 1'b0, 1'b1, 16'd1);
        check("fail_done_busy", 32'(bus.busy), 32'd1);
        no_resp(1'b1, 32'd84, 32'd7);
        check_flags("fail_sticky", 1'b0, 1'b1, 16'd1);

        // Correct pass store.
        pulse_reset();
        check_flags("rst2", 1'b0, 1'b0, 16'd0);
        do_req(1'b1, 32'd84, 32'd7, 1'b0, 32'd0);
        @(negedge clk);
        check_flags("pass", 1'b1, 1'b0, 16'd1);
        check("pass_done_busy", 32'(bus.busy), 32'd1);
        no_resp(1'b0, 32'd80, 32'd0);
        check_flags("pass_sticky", 1'b1, 1'b0, 16'd1);

        // Zero-wait instance: a held req is accepted only every second cycle.
        pulse_reset();
        for (int i = 0; i < 5; i++) sb0.push_back('{is_read: 1'b0, err: 1'b0, rdata: 32'd0});
        bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 32'd80; bus0.wdata = 32'h11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("w0_ready_pattern", 32'(bus0.ready), 32'(i % 2 == 0));
        end
        bus0.req = 1'b0;
        check("w0_wcount", 32'(wc0), 32'd5);
        check("w0_flags", {30'd0, pass0, fail0}, 32'd0);
        sb0.push_back('{is_read: 1'b1, err: 1'b0, rdata: 32'h11});
        bus0.req = 1'b1; bus0.we = 1'b0;
        @(negedge clk);
        bus0.req = 1'b0;
        check("w0_read_latency", 32'(bus0.ready), 32'd1);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("sb0_drained", 32'(sb0.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
